// File: rtl/rv_branch_ctrl.sv
// ============================================================================
// Module   : rv_branch_ctrl
// Purpose  : ID-stage branch/jump resolution; drives the shared comparator,
//            issues handshaked PC redirects and counts control flow.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_branch_ctrl #(
    parameter int BUS_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idValid,
    input  logic             idIsBranch,
    input  logic             idIsJal,
    input  logic             idIsJalr,
    input  logic [2:0]       idFunct3,
    input  logic [BUS_W-1:0] idPc,
    input  logic [BUS_W-1:0] idImm,
    input  logic [BUS_W-1:0] rs1Data,
    input  logic [BUS_W-1:0] rs2Data,
    input  logic             opReady,
    input  logic             flush,
    input  logic             cmpTaken,
    output logic [2:0]       cmpOp,
    output logic [BUS_W-1:0] cmpA,
    output logic [BUS_W-1:0] cmpB,
    output logic             stallID,
    output logic             flushIF,
    output logic             redirectValid,
    output logic [BUS_W-1:0] redirectPc,
    input  logic             redirectReady,
    output logic             linkValid,
    output logic [BUS_W-1:0] linkData,
    output logic             misalignErr,
    output logic [CNT_W-1:0] branchCnt,
    output logic [CNT_W-1:0] takenCnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_OPS = 2'd1;
    localparam logic [1:0] S_RESOLVE  = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [BUS_W-1:0] r_pc;
    logic [BUS_W-1:0] r_imm;
    logic             r_is_branch;
    logic             r_is_jal;
    logic             r_is_jalr;

    logic             w_ctl;
    logic             w_capture;
    logic             w_resolve;
    logic             w_take;
    logic             w_redirect;
    logic             w_misalign;
    logic             w_link;
    logic             w_accept;
    logic [BUS_W-1:0] w_base;
    logic [BUS_W-1:0] w_sum;
    logic [BUS_W-1:0] w_target;
    logic [BUS_W-1:0] w_link_pc;

    assign w_ctl = idValid & (idIsBranch | idIsJal | idIsJalr);

    // rs1 is held in cmpA, so JALR takes its base from the comparator operand.
    assign w_base    = r_is_jalr ? cmpA : r_pc;
    assign w_sum     = w_base + r_imm;
    assign w_target  = r_is_jalr ? {w_sum[BUS_W-1:1], 1'b0} : w_sum;
    assign w_link_pc = r_pc + BUS_W'(4);
    assign w_take    = r_is_jal | r_is_jalr | (r_is_branch & cmpTaken);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ctl) begin
                        w_next_state = opReady ? S_RESOLVE : S_WAIT_OPS;
                    end
                end
                S_WAIT_OPS: begin
                    if (opReady) begin
                        w_next_state = S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    w_next_state = (w_take & ~w_target[1]) ? S_REDIRECT : S_IDLE;
                end
                S_REDIRECT: begin
                    if (redirectReady) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        stallID    = 1'b0;
        w_capture  = 1'b0;
        w_resolve  = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stallID   = w_ctl;
                w_capture = w_ctl & opReady & ~flush;
            end
            S_WAIT_OPS: begin
                stallID   = 1'b1;
                w_capture = opReady & ~flush;
            end
            S_RESOLVE: begin
                stallID   = 1'b1;
                w_resolve = ~flush;
            end
            S_REDIRECT: begin
                stallID   = 1'b1;
                w_accept  = redirectValid & redirectReady & ~flush;
            end
            default: begin
                stallID   = 1'b0;
            end
        endcase
    end

    assign w_redirect = w_resolve & w_take & ~w_target[1];
    assign w_misalign = w_resolve & w_take &  w_target[1];
    assign w_link     = w_resolve & (r_is_jal | r_is_jalr);

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmpOp       <= 3'd0;
            cmpA        <= '0;
            cmpB        <= '0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_is_branch <= 1'b0;
            r_is_jal    <= 1'b0;
            r_is_jalr   <= 1'b0;
        end else if (w_capture) begin
            cmpOp       <= idFunct3;
            cmpA        <= rs1Data;
            cmpB        <= rs2Data;
            r_pc        <= idPc;
            r_imm       <= idImm;
            r_is_branch <= idIsBranch;
            r_is_jal    <= idIsJal;
            r_is_jalr   <= idIsJalr;
        end
    end

    // ------------------------------------------------------------------
    // Redirect handshake and result pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            flushIF       <= 1'b0;
            linkValid     <= 1'b0;
            linkData      <= '0;
            misalignErr   <= 1'b0;
        end else begin
            flushIF     <= w_redirect;
            linkValid   <= w_link;
            misalignErr <= w_misalign;
            if (w_link) begin
                linkData <= w_link_pc;
            end
            if (w_redirect) begin
                redirectPc <= w_target;
            end
            // A pending redirect only retires on acceptance or a flush.
            if (flush || w_accept) begin
                redirectValid <= 1'b0;
            end else if (w_redirect) begin
                redirectValid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branchCnt <= '0;
            takenCnt  <= '0;
        end else begin
            if (w_resolve && (branchCnt != {CNT_W{1'b1}})) begin
                branchCnt <= branchCnt + CNT_W'(1);
            end
            if (w_redirect && (takenCnt != {CNT_W{1'b1}})) begin
                takenCnt <= takenCnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_branch_ctrl.sv
// ============================================================================
// Module   : tb_rv_branch_ctrl
// Purpose  : Directed self-checking bench for rv_branch_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        idValid, idIsBranch, idIsJal, idIsJalr;
    logic [2:0]  idFunct3;
    logic [31:0] idPc, idImm, rs1Data, rs2Data;
    logic        opReady, flush, cmpTaken, redirectReady;

    logic [2:0]  cmpOp;
    logic [31:0] cmpA, cmpB, redirectPc, linkData;
    logic        stallID, flushIF, redirectValid, linkValid, misalignErr;
    logic [15:0] branchCnt, takenCnt;

    logic [2:0]  s_cmpOp;
    logic [31:0] s_cmpA, s_cmpB, s_redirectPc, s_linkData;
    logic        s_stallID, s_flushIF, s_redirectValid, s_linkValid, s_misalignErr;
    logic [3:0]  s_branchCnt, s_takenCnt;

    int n_total;
    int n_pass;

    rv_branch_ctrl #(.BUS_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idIsBranch(idIsBranch),
        .idIsJal(idIsJal), .idIsJalr(idIsJalr), .idFunct3(idFunct3),
        .idPc(idPc), .idImm(idImm), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .opReady(opReady), .flush(flush), .cmpTaken(cmpTaken),
        .cmpOp(cmpOp), .cmpA(cmpA), .cmpB(cmpB), .stallID(stallID),
        .flushIF(flushIF), .redirectValid(redirectValid), .redirectPc(redirectPc),
        .redirectReady(redirectReady), .linkValid(linkValid), .linkData(linkData),
        .misalignErr(misalignErr), .branchCnt(branchCnt), .takenCnt(takenCnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    rv_branch_ctrl #(.BUS_W(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .idValid(idValid), .idIsBranch(idIsBranch),
        .idIsJal(idIsJal), .idIsJalr(idIsJalr), .idFunct3(idFunct3),
        .idPc(idPc), .idImm(idImm), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .opReady(opReady), .flush(flush), .cmpTaken(cmpTaken),
        .cmpOp(s_cmpOp), .cmpA(s_cmpA), .cmpB(s_cmpB), .stallID(s_stallID),
        .flushIF(s_flushIF), .redirectValid(s_redirectValid), .redirectPc(s_redirectPc),
        .redirectReady(redirectReady), .linkValid(s_linkValid), .linkData(s_linkData),
        .misalignErr(s_misalignErr), .branchCnt(s_branchCnt), .takenCnt(s_takenCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        idValid = 0; idIsBranch = 0; idIsJal = 0; idIsJalr = 0;
        idFunct3 = 0; idPc = 0; idImm = 0; rs1Data = 0; rs2Data = 0; opReady = 0;
    endtask

    // kind: 0 = branch, 1 = JAL, 2 = JALR
    task automatic drive_id(input int kind, input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] a,
                            input logic [31:0] b, input logic rdy);
        idValid = 1; idIsBranch = (kind == 0); idIsJal = (kind == 1); idIsJalr = (kind == 2);
        idFunct3 = f3; idPc = pc; idImm = imm; rs1Data = a; rs2Data = b; opReady = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst = 1; clear_id(); flush = 0; cmpTaken = 0; redirectReady = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_id(); flush = 0; cmpTaken = 0; redirectReady = 0;
        step();
        n_total++; if ({redirectValid, flushIF, stallID, linkValid, misalignErr} !== 5'b0)
            $display("FAIL reset_ctrl: got %b exp 00000", {redirectValid, flushIF, stallID, linkValid, misalignErr}); else n_pass++;
        n_total++; if ({cmpOp, cmpA, cmpB} !== 67'b0)
            $display("FAIL reset_cmp: got %h/%h/%h exp 0", cmpOp, cmpA, cmpB); else n_pass++;
        n_total++; if ({redirectPc, linkData} !== 64'b0)
            $display("FAIL reset_pc: got %h/%h exp 0", redirectPc, linkData); else n_pass++;
        n_total++; if ({branchCnt, takenCnt} !== 32'b0)
            $display("FAIL reset_cnt: got %h/%h exp 0", branchCnt, takenCnt); else n_pass++;
        rst = 0;
    endtask

    task automatic test_beq_taken();
        do_reset();
        drive_id(0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1);
        n_total++; if (stallID !== 1'b1) $display("FAIL beq_stall_t0: got %b exp 1", stallID); else n_pass++;
        step();
        clear_id(); cmpTaken = 1; #1;
        n_total++; if ({cmpOp, cmpA, cmpB} !== {3'b000, 32'd5, 32'd5})
            $display("FAIL beq_operands: got %h/%h/%h exp 0/5/5", cmpOp, cmpA, cmpB); else n_pass++;
        n_total++; if (stallID !== 1'b1) $display("FAIL beq_stall_t1: got %b exp 1", stallID); else n_pass++;
        step();
        cmpTaken = 0;
        n_total++; if ({redirectValid, flushIF} !== 2'b11)
            $display("FAIL beq_redirect_t2: got %b exp 11", {redirectValid, flushIF}); else n_pass++;
        n_total++; if (redirectPc !== 32'h120) $display("FAIL beq_target: got %h exp 00000120", redirectPc); else n_pass++;
        n_total++; if ({branchCnt, takenCnt} !== {16'd1, 16'd1})
            $display("FAIL beq_counts: got %0d/%0d exp 1/1", branchCnt, takenCnt); else n_pass++;
        step();
        n_total++; if ({redirectValid, flushIF, stallID} !== 3'b101)
            $display("FAIL beq_t3_hold: got %b exp 101", {redirectValid, flushIF, stallID}); else n_pass++;
        redirectReady = 1;
        step();
        redirectReady = 0;
        n_total++; if ({redirectValid, stallID} !== 2'b00)
            $display("FAIL beq_accept_t4: got %b exp 00", {redirectValid, stallID}); else n_pass++;
        n_total++; if (takenCnt !== 16'd1) $display("FAIL beq_taken_after: got %0d exp 1", takenCnt); else n_pass++;
    endtask

    task automatic test_bne_not_taken();
        do_reset();
        drive_id(0, 3'b001, 32'h100, 32'h40, 32'd7, 32'd7, 1'b1);
        step();
        clear_id(); cmpTaken = 0; #1;
        n_total++; if (cmpOp !== 3'b001) $display("FAIL bne_op: got %b exp 001", cmpOp); else n_pass++;
        step();
        n_total++; if ({redirectValid, flushIF, stallID} !== 3'b000)
            $display("FAIL bne_no_redirect: got %b exp 000", {redirectValid, flushIF, stallID}); else n_pass++;
        n_total++; if ({branchCnt, takenCnt} !== {16'd1, 16'd0})
            $display("FAIL bne_counts: got %0d/%0d exp 1/0", branchCnt, takenCnt); else n_pass++;
    endtask

    task automatic test_jalr_wait();
        do_reset();
        drive_id(2, 3'b000, 32'h200, 32'h10, 32'h1001, 32'h0, 1'b0);
        n_total++; if (stallID !== 1'b1) $display("FAIL jalr_stall_t0: got %b exp 1", stallID); else n_pass++;
        step();
        n_total++; if ({stallID, cmpA} !== {1'b1, 32'h0})
            $display("FAIL jalr_wait_t1: got %b/%h exp 1/00000000", stallID, cmpA); else n_pass++;
        step();
        step();
        opReady = 1; #1;
        n_total++; if ({stallID, cmpA, linkValid} !== {1'b1, 32'h0, 1'b0})
            $display("FAIL jalr_wait_t3: got %b/%h/%b exp 1/00000000/0", stallID, cmpA, linkValid); else n_pass++;
        step();
        clear_id(); #1;
        n_total++; if ({cmpA, linkValid, stallID} !== {32'h1001, 1'b0, 1'b1})
            $display("FAIL jalr_resolve: got %h/%b/%b exp 00001001/0/1", cmpA, linkValid, stallID); else n_pass++;
        step();
        n_total++; if ({linkValid, linkData} !== {1'b1, 32'h204})
            $display("FAIL jalr_link: got %b/%h exp 1/00000204", linkValid, linkData); else n_pass++;
        n_total++; if ({redirectValid, redirectPc} !== {1'b1, 32'h1010})
            $display("FAIL jalr_target: got %b/%h exp 1/00001010", redirectValid, redirectPc); else n_pass++;
        redirectReady = 1;
        step();
        redirectReady = 0;
        n_total++; if ({linkValid, redirectValid, takenCnt} !== {1'b0, 1'b0, 16'd1})
            $display("FAIL jalr_done: got %b/%b/%0d exp 0/0/1", linkValid, redirectValid, takenCnt); else n_pass++;
    endtask

    task automatic test_jal_misalign();
        do_reset();
        drive_id(1, 3'b000, 32'h300, 32'h2, 32'h0, 32'h0, 1'b1);
        step();
        clear_id();
        step();
        n_total++; if ({misalignErr, linkValid, redirectValid, flushIF} !== 4'b1100)
            $display("FAIL jal_mis_pulses: got %b exp 1100", {misalignErr, linkValid, redirectValid, flushIF}); else n_pass++;
        n_total++; if (linkData !== 32'h304) $display("FAIL jal_mis_link: got %h exp 00000304", linkData); else n_pass++;
        n_total++; if ({branchCnt, takenCnt} !== {16'd1, 16'd0})
            $display("FAIL jal_mis_counts: got %0d/%0d exp 1/0", branchCnt, takenCnt); else n_pass++;
        step();
        n_total++; if ({misalignErr, linkValid, stallID} !== 3'b000)
            $display("FAIL jal_mis_after: got %b exp 000", {misalignErr, linkValid, stallID}); else n_pass++;
    endtask

    task automatic test_flush_redirect();
        do_reset();
        drive_id(0, 3'b000, 32'h400, 32'h8, 32'd1, 32'd1, 1'b1);
        step();
        clear_id(); cmpTaken = 1;
        step();
        cmpTaken = 0; redirectReady = 0;
        repeat (4) step();
        n_total++; if ({redirectValid, stallID, flushIF, redirectPc} !== {3'b110, 32'h408})
            $display("FAIL flush_hold: got %b%b%b/%h exp 110/00000408", redirectValid, stallID, flushIF, redirectPc); else n_pass++;
        step();
        flush = 1; redirectReady = 1;
        step();
        flush = 0; redirectReady = 0;
        n_total++; if ({redirectValid, stallID, flushIF} !== 3'b000)
            $display("FAIL flush_drop: got %b exp 000", {redirectValid, stallID, flushIF}); else n_pass++;
        n_total++; if (takenCnt !== 16'd1) $display("FAIL flush_taken: got %0d exp 1", takenCnt); else n_pass++;
        drive_id(0, 3'b001, 32'h480, 32'h8, 32'd1, 32'd2, 1'b1);
        step();
        clear_id(); cmpTaken = 0;
        step();
        n_total++; if ({branchCnt, redirectValid, stallID} !== {16'd2, 2'b00})
            $display("FAIL flush_idle_next: got %0d/%b/%b exp 2/0/0", branchCnt, redirectValid, stallID); else n_pass++;
    endtask

    task automatic test_flush_resolve();
        do_reset();
        drive_id(1, 3'b000, 32'h500, 32'h40, 32'h0, 32'h0, 1'b1);
        step();
        clear_id(); flush = 1;
        step();
        flush = 0;
        n_total++; if ({linkValid, redirectValid, flushIF, misalignErr, stallID} !== 5'b0)
            $display("FAIL flushres_pulses: got %b exp 00000", {linkValid, redirectValid, flushIF, misalignErr, stallID}); else n_pass++;
        n_total++; if ({branchCnt, takenCnt} !== 32'b0)
            $display("FAIL flushres_counts: got %0d/%0d exp 0/0", branchCnt, takenCnt); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        drive_id(0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'd3, 32'd3, 1'b1);
        step();
        clear_id(); cmpTaken = 1;
        step();
        cmpTaken = 0;
        n_total++; if ({redirectValid, misalignErr, redirectPc} !== {2'b10, 32'h10})
            $display("FAIL wrap_target: got %b%b/%h exp 10/00000010", redirectValid, misalignErr, redirectPc); else n_pass++;
        redirectReady = 1;
        step();
        redirectReady = 0;
    endtask

    task automatic test_back_to_back_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_id(0, 3'b001, 32'h600, 32'h10, 32'd1, 32'd2, 1'b1);
            step();
            clear_id(); cmpTaken = 0;
            step();
        end
        n_total++; if ({branchCnt, takenCnt} !== {16'd20, 16'd0})
            $display("FAIL b2b_counts: got %0d/%0d exp 20/0", branchCnt, takenCnt); else n_pass++;
        n_total++; if (s_branchCnt !== 4'hF) $display("FAIL sat_branch: got %h exp f", s_branchCnt); else n_pass++;
        for (int i = 0; i < 18; i++) begin
            drive_id(1, 3'b000, 32'h700, 32'h100, 32'h0, 32'h0, 1'b1);
            redirectReady = 1;
            step();
            clear_id();
            step();
            step();
        end
        redirectReady = 0;
        n_total++; if ({branchCnt, takenCnt} !== {16'd38, 16'd18})
            $display("FAIL sat_wide_counts: got %0d/%0d exp 38/18", branchCnt, takenCnt); else n_pass++;
        n_total++; if ({s_branchCnt, s_takenCnt} !== 8'hFF)
            $display("FAIL sat_narrow: got %h/%h exp f/f", s_branchCnt, s_takenCnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_id(0, 3'b000, 32'h800, 32'h40, 32'd9, 32'd9, 1'b1);
        step();
        clear_id(); cmpTaken = 1;
        step();
        cmpTaken = 0;
        n_total++; if (redirectValid !== 1'b1) $display("FAIL arst_pre: got %b exp 1", redirectValid); else n_pass++;
        #2 rst = 1;
        #1;
        n_total++; if ({redirectValid, flushIF, stallID, linkValid, misalignErr} !== 5'b0)
            $display("FAIL arst_ctrl: got %b exp 00000", {redirectValid, flushIF, stallID, linkValid, misalignErr}); else n_pass++;
        n_total++; if ({redirectPc, cmpA, cmpB, branchCnt, takenCnt} !== 128'b0)
            $display("FAIL arst_data: got %h/%h/%h/%0d/%0d exp 0", redirectPc, cmpA, cmpB, branchCnt, takenCnt); else n_pass++;
        step();
        rst = 0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1;
        clear_id();
        flush = 0; cmpTaken = 0; redirectReady = 0;
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_jalr_wait();
        test_jal_misalign();
        test_flush_redirect();
        test_flush_resolve();
        test_wrap();
        test_back_to_back_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_branch_ctrl.md
Name: rv_branch_ctrl

Overview:
- Branch/jump resolution controller in the ID stage.
- Sequences the shared branch comparator: captures operands when forwarding is resolved, drives comparator op/operands, computes the target and issues a handshaked PC redirect plus fetch flush to IF.
- Handles JAL/JALR link values, misaligned-target errors, a pipeline flush from later stages, and taken/total branch performance counters.

Parameters:
BUS_W, 32, datapath/PC width
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
idValid  in  1  ID holds a valid instruction
idIsBranch  in  1  conditional branch (B-type)
idIsJal  in  1  JAL
idIsJalr  in  1  JALR
idFunct3  in  3  branch funct3
idPc  in  BUS_W  instruction PC
idImm  in  BUS_W  sign-extended immediate
rs1Data  in  BUS_W  forwarded rs1
rs2Data  in  BUS_W  forwarded rs2
opReady  in  1  rs1/rs2 forwarding resolved this cycle
flush  in  1  trap/flush from later stage, highest priority
cmpTaken  in  1  comparator result
cmpOp  out  3  comparator op (registered)
cmpA  out  BUS_W  comparator operand A (registered)
cmpB  out  BUS_W  comparator operand B (registered)
stallID  out  1  hold ID stage
flushIF  out  1  kill the instruction in IF
redirectValid  out  1  redirect request to fetch
redirectPc  out  BUS_W  redirect target
redirectReady  in  1  fetch accepts redirect
linkValid  out  1  one-cycle pulse: write linkData to rd
linkData  out  BUS_W  idPc+4 of the jump
misalignErr  out  1  one-cycle pulse: target bit[1] set
branchCnt  out  CNT_W  resolved control-flow instructions
takenCnt  out  CNT_W  redirects issued

Behaviour:
- Reset (async, any state): state=IDLE; every output 0, including cmpOp/cmpA/cmpB, redirectPc, linkData and both counters. Reset mid-operation abandons any pending redirect; no pulse is emitted.
- States: IDLE, WAIT_OPS, RESOLVE, REDIRECT.
- Control-flow instruction (ctl) = idValid & (idIsBranch|idIsJal|idIsJalr). Only one of the three type flags is ever set.
- IDLE:
  - ctl & opReady: latch cmpOp=idFunct3, cmpA=rs1Data, cmpB=rs2Data, plus pc/imm/type/rs1 internally; go to RESOLVE.
  - ctl & !opReady: go to WAIT_OPS.
  - stallID=ctl in both cases. Otherwise stay in IDLE.
- WAIT_OPS: stallID=1. When opReady: latch as above; go to RESOLVE.
- RESOLVE (exactly 1 cycle): stallID=1.
  - Target: branch/JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared. Sum is modulo 2^BUS_W; wrap-around is not an error.
  - take = JAL | JALR | (branch & cmpTaken).
  - funct3 010/011 give cmpTaken=0 from the comparator and are treated as not-taken.
  - branchCnt increments, saturating at all-ones.
  - JAL/JALR: linkValid pulses with linkData=pc+4, including when misaligned.
  - take & target[1]=1: misalignErr pulses; no redirect; go to IDLE.
  - take & aligned: redirectPc=target, redirectValid=1, flushIF=1, takenCnt increments (saturating); go to REDIRECT.
  - Not taken: go to IDLE.
- REDIRECT: redirectValid, redirectPc and stallID are held stable.
  - flushIF=1 in the first REDIRECT cycle only.
  - On redirectValid & redirectReady: clear redirectValid and stallID next cycle; go to IDLE.
  - redirectValid never drops without acceptance, except on flush or reset.
- flush (any state): next state IDLE; redirectValid, stallID, flushIF, linkValid and misalignErr are 0 next cycle.
  - flush in RESOLVE suppresses counter updates and pulses.
  - flush with redirectReady in the same cycle: flush wins; the redirect counts as not accepted.
- Latency, ops ready: ctl at T0, RESOLVE at T1, redirectValid visible at T2. Not-taken releases stallID at T2.

Test Plan:
- BEQ, pc=0x100, imm=0x20, rs1=rs2=5, opReady=1, cmpTaken=1 -> T2: redirectValid=1, redirectPc=0x120, flushIF=1; redirectReady at T3 -> IDLE, stallID=0 at T4, takenCnt=1.
- BNE, rs1=rs2=7, cmpTaken=0 -> no redirect, branchCnt=1, takenCnt=0, stallID low from T2.
- JALR, pc=0x200, rs1=0x1001, imm=0x10, opReady low for 3 cycles -> 3 cycles in WAIT_OPS, then linkData=0x204 pulse, redirectPc=0x1010.
- JAL, pc=0x300, imm=0x2 -> target 0x302: misalignErr and linkValid pulse, no redirectValid, takenCnt unchanged.
- redirectReady held low 5 cycles then flush asserted -> redirectValid drops the next cycle, state IDLE, takenCnt still 1.
- Wrap and saturation: pc=0xFFFFFFF0, imm=0x20, taken -> redirectPc=0x00000010. Preload by 65535 branches -> branchCnt stays 0xFFFF. Async rst mid-REDIRECT -> all outputs 0 immediately.
